lb_baud_ctrl: RTL
=================

LB_BAUD_CTRL -- requirements
Module: lb_baud_ctrl

Interface
REQ-001 SHALL provide parameter RESET_SEL, default 4'd4, the baudSelect value applied at reset (9600 baud).
REQ-002 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL provide port wrStrobe, input, 1, a one-cycle CPU write of a new rate selection.
REQ-005 SHALL provide port wrData, input, 4, the requested selection, sampled when wrStrobe=1.
REQ-006 SHALL provide port clrErr, input, 1, which clears errInvalid.
REQ-007 SHALL provide port linkBusy, input, 1; while high, UART TX/RX is mid-frame and a rate change is deferred.
REQ-008 SHALL provide port counterValue, input, 20, the combinational divisor returned by the baud table for baudSelect.
REQ-009 SHALL provide port baudSelect, output, 4, the registered selection driving the baud table.
REQ-010 SHALL provide port baudTick, output, 1, a registered one-cycle pulse at the active baud rate.
REQ-011 SHALL provide port pending, output, 1, high while an accepted change awaits application.
REQ-012 SHALL provide port changeDone, output, 1, a one-cycle pulse when a new selection takes effect.
REQ-013 SHALL provide port errInvalid, output, 1, a sticky flag for a rejected write.

Function
REQ-014 SHALL implement FSM states LOAD, RUN and PEND, with an internal 20-bit down-counter cnt and a 4-bit register pendSel.
REQ-015 SHALL treat wrData 0..11 as valid; for 12..15 it ignores the write (no state or pendSel change) and sets errInvalid=1.
REQ-016 SHALL, when clrErr and an invalid write occur in the same cycle, set errInvalid (set wins).
REQ-017 SHALL, in RUN or PEND, on each edge: if cnt==0 then cnt<=counterValue and baudTick<=1; else cnt<=cnt-1 and baudTick<=0.
REQ-018 SHALL give a tick period of counterValue+1 clocks (650 -> 651 clocks); counterValue=0 yields baudTick high every cycle.
REQ-019 SHALL, on a valid write in RUN, set pendSel<=wrData and pending<=1, then go to PEND.
REQ-020 SHALL, on a valid write in PEND, overwrite pendSel (last write wins) and stay in PEND that cycle regardless of linkBusy.
REQ-021 SHALL, in PEND with linkBusy=0 and no valid write, set baudSelect<=pendSel and pending<=0, then go to LOAD.
REQ-022 SHALL keep ticking at the old rate in PEND for as long as linkBusy=1, with no timeout.
REQ-023 SHALL, in LOAD, set cnt<=counterValue (the table output for the current baudSelect), baudTick<=0 and changeDone<=1.
REQ-024 SHALL leave LOAD for RUN, or for PEND if a valid write occurs in the LOAD cycle (captured per REQ-019).
REQ-025 SHALL place the first tick after a change counterValue+1 clocks after the LOAD cycle.
REQ-026 SHALL process a valid write equal to the current baudSelect as a normal change, which restarts the tick phase.
REQ-027 SHALL hold changeDone high for exactly the cycle after LOAD and low otherwise.
REQ-028 SHALL keep baudSelect stable except on the PEND->LOAD transition and at reset.

Reset
REQ-029 SHALL, on rst_n low (asynchronous), force state=LOAD, baudSelect=RESET_SEL, cnt=0, pendSel=RESET_SEL, baudTick=0, pending=0, changeDone=0, errInvalid=0.
REQ-030 SHALL, in the first edge after rst_n releases, execute LOAD and pulse changeDone.
REQ-031 SHALL, on reset mid-PEND, discard the pending request and restart at RESET_SEL.

Verification
REQ-032 SHALL cover: reset release with counterValue=650 -> changeDone pulse, then baudTick every 651 clocks.
REQ-033 SHALL cover: write 4'd11 with linkBusy=1 for 2000 cycles -> pending=1, old-rate ticks continue, baudSelect unchanged; linkBusy->0 -> baudSelect=11 next edge, changeDone, first tick counterValue+1 clocks after LOAD.
REQ-034 SHALL cover: writes 5 then 7 on consecutive cycles in PEND with linkBusy=1 -> applied baudSelect=7, a single changeDone.
REQ-035 SHALL cover: write 4'd13 -> errInvalid=1, pending=0, baudSelect unchanged; invalid write with simultaneous clrErr -> errInvalid=1; clrErr alone -> 0.
REQ-036 SHALL cover: counterValue=0 -> baudTick continuously high in RUN; rst_n asserted mid-PEND -> all outputs reset immediately (asynchronously), baudSelect=4.
REQ-037 SHALL cover: valid write in the LOAD cycle -> cnt reloads, next state PEND, pending=1.

Source files
------------

// File: rtl/lb_baud_ctrl.sv
// Baud-rate control for a UART link: holds the active rate selection,
// generates the baud tick from the table divisor, and defers CPU rate
// changes until the link is idle.
module lb_baud_ctrl #(
    parameter logic [3:0] RESET_SEL = 4'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrStrobe,
    input  logic [3:0]  wrData,
    input  logic        clrErr,
    input  logic        linkBusy,
    input  logic [19:0] counterValue,
    output logic [3:0]  baudSelect,
    output logic        baudTick,
    output logic        pending,
    output logic        changeDone,
    output logic        errInvalid
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [19:0] cnt;
    logic [19:0] cnt_nx;
    logic [3:0]  pend_sel;
    logic [3:0]  pend_sel_nx;
    logic [3:0]  sel_nx;
    logic        tick_nx;
    logic        pending_nx;
    logic        done_nx;
    logic        err_nx;
    logic        wr_valid;
    logic        wr_invalid;

    assign wr_valid   = wrStrobe && (wrData < 4'd12);
    assign wr_invalid = wrStrobe && (wrData >= 4'd12);

    // Next-state, divisor counter and output decode; a rejected write sets the
    // error flag and otherwise has no effect, and setting beats clearing.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        pend_sel_nx = pend_sel;
        sel_nx      = baudSelect;
        tick_nx     = 1'b0;
        pending_nx  = pending;
        done_nx     = 1'b0;
        err_nx      = wr_invalid ? 1'b1 : (clrErr ? 1'b0 : errInvalid);

        case (state)
            LOAD: begin
                cnt_nx  = counterValue;
                done_nx = 1'b1;
                if (wr_valid) begin
                    pend_sel_nx = wrData;
                    pending_nx  = 1'b1;
                    state_nx    = PEND;
                end else begin
                    state_nx = RUN;
                end
            end
            RUN, PEND: begin
                if (cnt == '0) begin
                    cnt_nx  = counterValue;
                    tick_nx = 1'b1;
                end else begin
                    cnt_nx = cnt - 20'd1;
                end
                if (wr_valid) begin
                    pend_sel_nx = wrData;
                    pending_nx  = 1'b1;
                    state_nx    = PEND;
                end else if ((state == PEND) && !linkBusy) begin
                    sel_nx     = pend_sel;
                    pending_nx = 1'b0;
                    state_nx   = LOAD;
                end
            end
            default: begin
                state_nx = LOAD;
            end
        endcase
    end

    // State and output registers; reset restarts from LOAD at the reset rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            cnt        <= '0;
            pend_sel   <= RESET_SEL;
            baudSelect <= RESET_SEL;
            baudTick   <= 1'b0;
            pending    <= 1'b0;
            changeDone <= 1'b0;
            errInvalid <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            pend_sel   <= pend_sel_nx;
            baudSelect <= sel_nx;
            baudTick   <= tick_nx;
            pending    <= pending_nx;
            changeDone <= done_nx;
            errInvalid <= err_nx;
        end
    end

endmodule
